// File: rtl/fos_out_requant.sv
// Output requantiser for the first-order IIR section: round-half-up, shift,
// saturate to OUT_W, then buffer in a first-word-fall-through FIFO with stats.
module fos_out_requant #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 10,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [IN_W-1:0]    y_in,
  input  logic                      y_valid,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      clr_stats,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic [15:0]               sat_count,
  output logic [15:0]               drop_count
);

  localparam int Q_W   = IN_W + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic signed [Q_W-1:0]   HALF    = Q_W'(1) << (SHIFT - 1);
  localparam logic signed [Q_W-1:0]   Q_MAX   = {{(Q_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [Q_W-1:0]   Q_MIN   = {{(Q_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  if (SHIFT < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
    $error("fos_out_requant: SHIFT must be >= 1 and DEPTH a power of two >= 2");
  end

  // One extra bit of headroom so adding the rounding half never wraps.
  logic signed [Q_W-1:0] w_sum;
  logic signed [Q_W-1:0] w_q;
  assign w_sum = $signed({y_in[IN_W-1], y_in}) + HALF;
  assign w_q   = w_sum >>> SHIFT;

  logic                  r_s1_valid;
  logic signed [Q_W-1:0] r_s1_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_q     <= '0;
    end else begin
      r_s1_valid <= y_valid;
      if (y_valid) r_s1_q <= w_q;
    end
  end

  logic w_hi;
  logic w_lo;
  assign w_hi = (r_s1_q > Q_MAX);
  assign w_lo = (r_s1_q < Q_MIN);

  logic                    r_s2_valid;
  logic                    r_s2_clip;
  logic signed [OUT_W-1:0] r_s2_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_valid <= 1'b0;
      r_s2_clip  <= 1'b0;
      r_s2_data  <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_clip <= w_hi | w_lo;
        r_s2_data <= w_hi ? OUT_MAX : (w_lo ? OUT_MIN : r_s1_q[OUT_W-1:0]);
      end
    end
  end

  // Sink handshake: an entry transfers on any edge where out_valid and
  // out_ready are both high; while out_valid=1 and out_ready=0 the head holds.
  logic [OUT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  assign w_full = (r_level == LVL_W'(DEPTH));
  assign w_pop  = out_valid & out_ready;
  assign w_push = r_s2_valid & (~w_full | w_pop);
  assign w_drop = r_s2_valid & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_s2_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign out_valid  = (r_level != '0);
  assign out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
  assign fifo_level = r_level;

  // Clear takes priority over a coincident increment.
  logic [15:0] r_sat_count;
  logic [15:0] r_drop_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sat_count  <= '0;
      r_drop_count <= '0;
    end else if (clr_stats) begin
      r_sat_count  <= '0;
      r_drop_count <= '0;
    end else begin
      if (r_s2_valid && r_s2_clip && r_sat_count != 16'hFFFF)
        r_sat_count <= r_sat_count + 16'd1;
      if (w_drop && r_drop_count != 16'hFFFF)
        r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign sat_count  = r_sat_count;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_fos_out_requant.sv
// Directed bench for fos_out_requant: vector table for rounding/saturation,
// hand-written sequences for backpressure, full+pop, counters and reset.
module tb_fos_out_requant;

  logic               clk;
  logic               reset;
  logic signed [31:0] y_in;
  logic               y_valid;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               clr_stats;
  logic [2:0]         fifo_level;
  logic [15:0]        sat_count;
  logic [15:0]        drop_count;

  fos_out_requant #(.IN_W(32), .OUT_W(16), .SHIFT(10), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .y_in       (y_in),
    .y_valid    (y_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .clr_stats  (clr_stats),
    .fifo_level (fifo_level),
    .sat_count  (sat_count),
    .drop_count (drop_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit sb_en  = 1'b0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic signed [31:0] y;
    logic signed [15:0] exp;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every accepted output must match the head of exp_q
  always @(negedge clk) begin
    if (sb_en && reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%0h expected=none at %0t", out_data, $time);
      end else begin
        check("sb_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'sd1024,      16'sd1};
    tbl[1] = '{32'sd1535,      16'sd1};
    tbl[2] = '{32'sd1536,      16'sd2};
    tbl[3] = '{-32'sd1536,     -16'sd1};
    tbl[4] = '{-32'sd1537,     -16'sd2};
    tbl[5] = '{32'sd0,         16'sd0};
    tbl[6] = '{32'sh7FFFFFFF,  16'sd32767};
    tbl[7] = '{32'sh80000000,  -16'sd32768};
    tbl[8] = '{32'sd33553919,  16'sd32767};
    tbl[9] = '{32'sd33553920,  16'sd32767};

    reset = 1'b0; y_in = '0; y_valid = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_level", 16'(fifo_level), 16'd0);
    check("rst_sat", sat_count, 16'd0);
    check("rst_drop", drop_count, 16'd0);
    check("rst_data", out_data, 16'd0);
    reset = 1'b1;
    tick();

    // rounding with latency checks on the first sample
    sb_en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      y_in = tbl[i].y; y_valid = 1'b1; exp_q.push_back(tbl[i].exp);
      tick();
      if (i == 0) check("lat_e0_valid", 16'(out_valid), 16'd0);
      if (i == 1) check("lat_e1_valid", 16'(out_valid), 16'd0);
      if (i == 2) begin
        check("lat_e2_valid", 16'(out_valid), 16'd1);
        check("lat_e2_data", out_data, 16'd1);
      end
    end
    y_valid = 1'b0;
    repeat (4) tick();
    check("round_sat", sat_count, 16'd0);
    check("round_drained", 16'(exp_q.size()), 16'd0);

    // saturation
    for (int i = 6; i < 10; i++) begin
      y_in = tbl[i].y; y_valid = 1'b1; exp_q.push_back(tbl[i].exp);
      tick();
    end
    y_valid = 1'b0;
    repeat (4) tick();
    check("sat_count3", sat_count, 16'd3);
    check("sat_drop", drop_count, 16'd0);
    check("sat_drained", 16'(exp_q.size()), 16'd0);

    // backpressure: 6 samples into a 4-deep FIFO
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      y_in = 32'(1024 * k); y_valid = 1'b1;
      if (k <= 4) exp_q.push_back(16'(k));
      tick();
    end
    y_valid = 1'b0;
    repeat (3) tick();
    check("bp_level", 16'(fifo_level), 16'd4);
    check("bp_drop", drop_count, 16'd2);
    check("bp_valid", 16'(out_valid), 16'd1);
    check("bp_head", out_data, 16'd1);
    repeat (2) tick();
    check("bp_hold", out_data, 16'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_drain_level", 16'(fifo_level), 16'(3 - i));
    end
    out_ready = 1'b0;
    check("bp_drained", 16'(exp_q.size()), 16'd0);

    // full FIFO with a push and a pop on the same edge
    for (int k = 11; k <= 14; k++) begin
      y_in = 32'(1024 * k); y_valid = 1'b1; exp_q.push_back(16'(k));
      tick();
    end
    y_valid = 1'b0;
    repeat (3) tick();
    check("fp_level_full", 16'(fifo_level), 16'd4);
    y_in = 32'(1024 * 15); y_valid = 1'b1; exp_q.push_back(16'd15);
    tick();
    y_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("fp_level", 16'(fifo_level), 16'd4);
    check("fp_drop", drop_count, 16'd2);
    check("fp_head", out_data, 16'd12);
    out_ready = 1'b1;
    repeat (5) tick();
    check("fp_drained", 16'(exp_q.size()), 16'd0);
    check("fp_empty", 16'(fifo_level), 16'd0);

    // sticky saturation counter, then clear racing an increment
    sb_en = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      y_in = 32'sh7FFFFFFF; y_valid = 1'b1;
      tick();
    end
    y_valid = 1'b0;
    repeat (4) tick();
    check("sat_sticky", sat_count, 16'hFFFF);
    check("sat_no_drop", drop_count, 16'd2);
    y_in = 32'sh7FFFFFFF; y_valid = 1'b1;
    tick();
    y_valid = 1'b0;
    tick();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("clr_sat", sat_count, 16'd0);
    check("clr_drop", drop_count, 16'd0);
    tick();
    check("clr_sat_after", sat_count, 16'd0);
    repeat (3) tick();
    sb_en = 1'b1;

    // asynchronous reset with 3 queued and 2 in flight
    out_ready = 1'b0;
    for (int k = 21; k <= 25; k++) begin
      y_in = (k == 21) ? 32'sh7FFFFFFF : 32'(1024 * k); y_valid = 1'b1;
      tick();
    end
    y_valid = 1'b0;
    check("pre_rst_level", 16'(fifo_level), 16'd3);
    check("pre_rst_sat", sat_count, 16'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", 16'(out_valid), 16'd0);
    check("arst_level", 16'(fifo_level), 16'd0);
    check("arst_sat", sat_count, 16'd0);
    check("arst_drop", drop_count, 16'd0);
    check("arst_data", out_data, 16'd0);
    exp_q.delete();
    @(posedge clk);
    #3 reset = 1'b1;
    tick();
    repeat (2) tick();
    check("post_rst_level", 16'(fifo_level), 16'd0);
    y_in = 32'(1024 * 7); y_valid = 1'b1; exp_q.push_back(16'd7);
    tick();
    y_valid = 1'b0;
    check("post_lat_e0", 16'(out_valid), 16'd0);
    tick();
    check("post_lat_e1", 16'(out_valid), 16'd0);
    tick();
    check("post_lat_e2_valid", 16'(out_valid), 16'd1);
    check("post_lat_e2_data", out_data, 16'd7);
    repeat (3) tick();
    check("post_no_stale", 16'(fifo_level), 16'd1);
    out_ready = 1'b1;
    tick();
    check("post_drain_level", 16'(fifo_level), 16'd0);
    check("post_drained", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
